// File: rtl/if_fetch_unit.sv
// if_fetch_unit: PC generator and imem request/response front end feeding IF/DC through an in-order buffer
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2,
  parameter logic [31:0] NOP_INST   = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        is_stay,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic [31:0] new_inst,
  output logic [31:0] new_pc,
  output logic        new_valid
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW-1:0] LAST = PW'(FIFO_DEPTH - 1);

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [CW-1:0] inflight_q, inflight_d, drop_cnt_q, drop_cnt_d, fifo_cnt_q, fifo_cnt_d;
  logic [PW-1:0] pq_wr_q, pq_wr_d, pq_rd_q, pq_rd_d, fq_wr_q, fq_wr_d, fq_rd_q, fq_rd_d;
  logic [31:0]   pq_pc_q [FIFO_DEPTH];
  logic [31:0]   fifo_pc_q [FIFO_DEPTH];
  logic [31:0]   fifo_inst_q [FIFO_DEPTH];
  logic          hs, resp, push, pop;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return p == LAST ? '0 : p + 1'b1;
  endfunction

  // Credits cover both in-flight requests and buffered entries so the buffer can never overflow
  assign imem_req_valid = !reset && !redirect_valid &&
                          ((CW+1)'(inflight_q) + (CW+1)'(fifo_cnt_q) < (CW+1)'(FIFO_DEPTH));
  assign imem_req_addr  = fetch_pc_q;
  assign new_valid      = fifo_cnt_q != '0;
  assign new_inst       = new_valid ? fifo_inst_q[fq_rd_q] : NOP_INST;
  assign new_pc         = new_valid ? fifo_pc_q[fq_rd_q] : 32'h0;

  always_comb begin
    hs         = imem_req_valid && imem_req_ready;
    resp       = imem_resp_valid && inflight_q != '0;
    push       = resp && drop_cnt_q == '0 && !redirect_valid;
    pop        = new_valid && !is_stay && !redirect_valid;
    inflight_d = inflight_q + CW'(hs) - CW'(resp);
    drop_cnt_d = redirect_valid ? inflight_d :
                 (resp && drop_cnt_q != '0) ? drop_cnt_q - 1'b1 : drop_cnt_q;
    fetch_pc_d = redirect_valid ? (redirect_pc & ~32'h3) : hs ? fetch_pc_q + 32'd4 : fetch_pc_q;
    fifo_cnt_d = redirect_valid ? '0 : fifo_cnt_q + CW'(push) - CW'(pop);
    fq_wr_d    = redirect_valid ? '0 : push ? nxt(fq_wr_q) : fq_wr_q;
    fq_rd_d    = redirect_valid ? '0 : pop ? nxt(fq_rd_q) : fq_rd_q;
    pq_wr_d    = hs ? nxt(pq_wr_q) : pq_wr_q;
    pq_rd_d    = resp ? nxt(pq_rd_q) : pq_rd_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      inflight_q <= '0;
      drop_cnt_q <= '0;
      fifo_cnt_q <= '0;
      pq_wr_q    <= '0;
      pq_rd_q    <= '0;
      fq_wr_q    <= '0;
      fq_rd_q    <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      inflight_q <= inflight_d;
      drop_cnt_q <= drop_cnt_d;
      fifo_cnt_q <= fifo_cnt_d;
      pq_wr_q    <= pq_wr_d;
      pq_rd_q    <= pq_rd_d;
      fq_wr_q    <= fq_wr_d;
      fq_rd_q    <= fq_rd_d;
      if (hs) pq_pc_q[pq_wr_q] <= fetch_pc_q;
      if (push) begin
        fifo_pc_q[fq_wr_q]   <= pq_pc_q[pq_rd_q];
        fifo_inst_q[fq_wr_q] <= imem_resp_data;
      end
    end
  end
endmodule
